// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions for the arbiter: state encodings, bus polarity
// constants, bus widths and the bus transfer payload.
`timescale 1ns/1ps
package bus_arbiter_pkg;

    localparam int unsigned BUS_ADDR_WIDTH = 16;
    localparam int unsigned DATA_WIDTH     = 16;

    localparam logic Enable_  = 1'b0;
    localparam logic Disable_ = 1'b1;
    localparam logic Read     = 1'b1;
    localparam logic Write    = 1'b0;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_TURN  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [BUS_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     wdata;
        logic                      rw_;
    } bus_xfer_t;

endpackage

// File: rtl/bus_arbiter_arb_select.sv
// Combinational requester search: first active-low request at or after
// i_base, wrapping around; returns its index and a valid flag.
`timescale 1ns/1ps
module arb_select #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req_n,
    input  logic [IW-1:0]   i_base,
    output logic [IW-1:0]   o_idx,
    output logic            o_valid
);

    int j;

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        j       = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            j = int'(i_base) + k;
            if (j >= int'(NREQ)) j = j - int'(NREQ);
            if (!o_valid && !i_req_n[IW'(j)]) begin
                o_valid = 1'b1;
                o_idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter with one-cycle owner turnaround, optional tenure limit
// and owner-steered bus mux. ARB_ROUND_ROBIN_EN selects round-robin policy.
`timescale 1ns/1ps
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic                           clk,
    input  logic                           reset_,
    input  logic [NREQ-1:0]                breq_,
    output logic [NREQ-1:0]                bgrt_,
    input  logic [NREQ*BUS_ADDR_WIDTH-1:0] m_addr,
    input  logic [NREQ*DATA_WIDTH-1:0]     m_odata,
    input  logic [NREQ-1:0]                m_rw_,
    output logic [BUS_ADDR_WIDTH-1:0]      bus_addr,
    output logic [DATA_WIDTH-1:0]          bus_wdata,
    output logic                           bus_rw_,
    output logic [$clog2(NREQ)-1:0]        bus_owner,
    output logic                           bus_busy
);

    localparam int unsigned OW        = $clog2(NREQ);
    localparam int unsigned HW        = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    arb_state_t      r_state;
    logic [NREQ-1:0] r_bgrt_;
    logic [OW-1:0]   r_owner;
    logic            r_busy;
    logic [HW-1:0]   r_hold_cnt;

    logic [OW-1:0]   w_base;
    logic [OW-1:0]   w_sel_idx;
    logic            w_sel_valid;
    logic [NREQ-1:0] w_owner_mask;
    logic            w_owner_rel;
    logic            w_others;
    logic            w_preempt;
    bus_xfer_t       w_xfer;

`ifdef ARB_ROUND_ROBIN_EN
    logic [OW-1:0]   r_rr_ptr;
    assign w_base = r_rr_ptr;
`else
    assign w_base = '0;
`endif

    arb_select #(.NREQ(NREQ)) u_select (
        .i_req_n (breq_),
        .i_base  (w_base),
        .o_idx   (w_sel_idx),
        .o_valid (w_sel_valid)
    );

    assign w_owner_mask = NREQ'(1) << r_owner;
    assign w_owner_rel  = breq_[r_owner];
    assign w_others     = |(~breq_ & ~w_owner_mask);
    assign w_preempt    = (MAX_HOLD != 0) && (r_hold_cnt == HW'(HOLD_LAST)) && w_others;

    // Arbitration FSM; every grant-side output is registered here.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state    <= ARB_IDLE;
            r_bgrt_    <= {NREQ{Disable_}};
            r_owner    <= '0;
            r_busy     <= 1'b0;
            r_hold_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr_ptr   <= '0;
`endif
        end else begin
            case (r_state)
                ARB_IDLE, ARB_TURN: begin
                    if (w_sel_valid) begin
                        r_state    <= ARB_GRANT;
                        r_bgrt_    <= ~(NREQ'(1) << w_sel_idx);
                        r_owner    <= w_sel_idx;
                        r_busy     <= 1'b1;
                        r_hold_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        r_rr_ptr   <= (w_sel_idx == OW'(NREQ - 1)) ? '0 : w_sel_idx + OW'(1);
`endif
                    end else begin
                        r_state <= ARB_IDLE;
                        r_bgrt_ <= {NREQ{Disable_}};
                        r_busy  <= 1'b0;
                    end
                end
                ARB_GRANT: begin
                    // Owner release wins over preemption; both go through a dead cycle.
                    if (w_owner_rel || w_preempt) begin
                        r_state <= ARB_TURN;
                        r_bgrt_ <= {NREQ{Disable_}};
                        r_busy  <= 1'b0;
                    end else if (r_hold_cnt < HW'(HOLD_LAST)) begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_bgrt_ <= {NREQ{Disable_}};
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Bus steering from the registered owner; idle bus parks at address 0, read.
    always_comb begin
        w_xfer.addr  = '0;
        w_xfer.wdata = '0;
        w_xfer.rw_   = Read;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (r_busy && (r_owner == OW'(i))) begin
                w_xfer.addr  = m_addr[i*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH];
                w_xfer.wdata = m_odata[i*DATA_WIDTH +: DATA_WIDTH];
                w_xfer.rw_   = m_rw_[i];
            end
        end
    end

    assign bgrt_     = r_bgrt_;
    assign bus_owner = r_owner;
    assign bus_busy  = r_busy;
    assign bus_addr  = w_xfer.addr;
    assign bus_wdata = w_xfer.wdata;
    assign bus_rw_   = w_xfer.rw_;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (NREQ=4, MAX_HOLD=4) against a
// tenure-based reference model; follows ARB_ROUND_ROBIN_EN when defined.
`timescale 1ns/1ps
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int MAXH = 4;
    localparam int AW   = BUS_ADDR_WIDTH;
    localparam int DW   = DATA_WIDTH;

    logic              clk;
    logic              reset_;
    logic [N-1:0]      breq_;
    logic [N-1:0]      bgrt_;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_odata;
    logic [N-1:0]      m_rw_;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic              bus_rw_;
    logic [1:0]        bus_owner;
    logic              bus_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current owner (-1 = none), cycles held, next search start.
    int m_owner  = -1;
    int m_tenure = 0;
    int m_ptr    = 0;

    bus_arbiter #(.NREQ(N), .MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .breq_     (breq_),
        .bgrt_     (bgrt_),
        .m_addr    (m_addr),
        .m_odata   (m_odata),
        .m_rw_     (m_rw_),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rw_   (bus_rw_),
        .bus_owner (bus_owner),
        .bus_busy  (bus_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] req);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++) begin
            if (!req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (!req[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_tenure = 0;
        m_ptr    = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] req);
        bit others;
        int w;
        if (m_owner >= 0) begin
            others = 1'b0;
            for (int i = 0; i < N; i++)
                if (i != m_owner && !req[i]) others = 1'b1;
            if (req[m_owner])
                m_owner = -1;
            else if (MAXH != 0 && m_tenure >= MAXH && others)
                m_owner = -1;
            else
                m_tenure++;
        end else begin
            w = pick(req);
            if (w >= 0) begin
                m_owner  = w;
                m_tenure = 1;
                m_ptr    = (w + 1) % N;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0] exp_g;
        exp_g = '1;
        if (m_owner >= 0) exp_g[m_owner] = 1'b0;
        check_eq($sformatf("%s.bgrt", tag), 32'(bgrt_), 32'(exp_g));
        check_eq($sformatf("%s.busy", tag), 32'(bus_busy), 32'(m_owner >= 0));
        if (m_owner >= 0) begin
            check_eq($sformatf("%s.owner", tag), 32'(bus_owner), 32'(m_owner));
            check_eq($sformatf("%s.addr", tag), 32'(bus_addr), 32'(m_addr[m_owner*AW +: AW]));
            check_eq($sformatf("%s.wdata", tag), 32'(bus_wdata), 32'(m_odata[m_owner*DW +: DW]));
            check_eq($sformatf("%s.rw", tag), 32'(bus_rw_), 32'(m_rw_[m_owner]));
        end else begin
            check_eq($sformatf("%s.addr", tag), 32'(bus_addr), 32'd0);
            check_eq($sformatf("%s.wdata", tag), 32'(bus_wdata), 32'd0);
            check_eq($sformatf("%s.rw", tag), 32'(bus_rw_), 32'd1);
        end
    endtask

    // One clock: model sees the inputs at the edge, outputs checked at the next negedge.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge(breq_);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            m_addr[i*AW +: AW]  = AW'($urandom);
            m_odata[i*DW +: DW] = DW'($urandom);
        end
        m_rw_ = N'($urandom);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_ = 1'b0;
        model_reset();
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int owners[$];
        logic prev_busy;
        logic [N-1:0] exp_seq;

        reset_ = 1'b0;
        breq_  = '1;
        rand_data();
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst.bgrt", 32'(bgrt_), 32'hF);
        check_eq("rst.busy", 32'(bus_busy), 32'd0);
        check_eq("rst.rw", 32'(bus_rw_), 32'd1);
        check_eq("rst.addr", 32'(bus_addr), 32'd0);
        reset_ = 1'b1;
        step("idle");

        // Single master grant and release
        breq_ = 4'b1101;
        step("t2");
        check_eq("t2.grant", 32'(bgrt_), 32'b1101);
        check_eq("t2.owner1", 32'(bus_owner), 32'd1);
        check_eq("t2.addr1", 32'(bus_addr), 32'(m_addr[1*AW +: AW]));
        for (int i = 0; i < 4; i++) step("t2.hold");
        breq_ = '1;
        step("t2.rel");
        check_eq("t2.released", 32'(bgrt_), 32'hF);
        step("t2.idle");
        check_eq("t2.idlebusy", 32'(bus_busy), 32'd0);

        // All masters requesting: 8 successive grants
        pulse_reset();
        breq_     = 4'b0000;
        prev_busy = 1'b0;
        for (int c = 0; c < 100 && owners.size() < 8; c++) begin
            step("t3");
            if (bus_busy && !prev_busy) owners.push_back(int'(bus_owner));
            prev_busy = bus_busy;
        end
        check_eq("t3.ngrants", 32'(owners.size()), 32'd8);
        for (int i = 0; i < owners.size(); i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            check_eq($sformatf("t3.owner%0d", i), 32'(owners[i]), 32'(i % N));
`else
            check_eq($sformatf("t3.owner%0d", i), 32'(owners[i]), 32'd0);
`endif
        end
        breq_ = '1;
        step("t3.rel");
        step("t3.idle");

        // Preemption of master 2 by waiting master 0
        breq_ = 4'b1011;
        step("t4");
        check_eq("t4.grant2", 32'(bgrt_), 32'b1011);
        breq_ = 4'b1010;
        cnt = 1;
        for (int c = 0; c < 10; c++) begin
            step("t4.hold");
            if (bgrt_[2] !== 1'b0) break;
            cnt++;
        end
        check_eq("t4.tenure", 32'(cnt), 32'(MAXH));
        check_eq("t4.dead", 32'(bgrt_), 32'hF);
        step("t4.next");
        check_eq("t4.grant0", 32'(bgrt_), 32'b1110);
        breq_ = '1;
        step("t4.rel");
        step("t4.idle");

        // Release coinciding with preemption point
        breq_ = 4'b1011;
        step("t5");
        breq_ = 4'b1001;
        for (int i = 0; i < 3; i++) step("t5.hold");
        breq_ = 4'b1101;
        step("t5.rel");
        check_eq("t5.dead", 32'(bgrt_), 32'hF);
        step("t5.next");
        check_eq("t5.grant1", 32'(bgrt_), 32'b1101);
        breq_ = '1;
        step("t5.rel2");
        step("t5.idle");

        // Asynchronous reset mid-grant
        breq_ = 4'b0111;
        step("t6");
        check_eq("t6.grant3", 32'(bgrt_), 32'b0111);
        step("t6.hold");
        #2;
        reset_ = 1'b0;
        #1;
        check_eq("t6.rstbgrt", 32'(bgrt_), 32'hF);
        check_eq("t6.rstbusy", 32'(bus_busy), 32'd0);
        model_reset();
        @(negedge clk);
        reset_ = 1'b1;
        step("t6.after");
        check_eq("t6.regrant", 32'(bgrt_), 32'b0111);
        breq_ = '1;
        step("t6.rel");
        step("t6.idle");

        // Randomized sticky requests with changing bus data
        for (int c = 0; c < 400; c++) begin
            exp_seq = breq_;
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) exp_seq[i] = ~exp_seq[i];
            breq_ = exp_seq;
            rand_data();
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
